// File: rtl/b_source_sequencer_if.sv
// Handshake bundle between decode/timing logic and the B-side load sequencer.
interface b_source_sequencer_if;
  logic [2:0] req;
  logic       flush;
  logic       invalidate;
  logic       load_not_db;
  logic       load_db;
  logic       load_adr;
  logic [2:0] ack;
  logic       busy;
  logic       b_valid;
  logic [1:0] b_src;

  modport master (
    output req, flush, invalidate,
    input  load_not_db, load_db, load_adr,
    input  ack, busy, b_valid, b_src
  );

  modport slave (
    input  req, flush, invalidate,
    output load_not_db, load_db, load_adr,
    output ack, busy, b_valid, b_src
  );
endinterface

// File: rtl/b_source_sequencer.sv
// ALU B-input load sequencer: arbitrate, hold one-hot strobe, then ack.
// Build option B_SEQ_ROUND_ROBIN_EN selects round-robin arbitration.
module b_source_sequencer #(
  parameter int LOAD_CYCLES = 1,
  parameter int CNT_W       = 4
) (
  input logic                 clk,
  input logic                 reset,
  b_source_sequencer_if.slave bus
);

  localparam int LC = (LOAD_CYCLES < 1) ? 1 : LOAD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LC - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACK
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       grant, grant_nx;
  logic [1:0]       pick;
  logic             b_valid_q, b_valid_nx;
  logic [1:0]       b_src_q, b_src_nx;

`ifdef B_SEQ_ROUND_ROBIN_EN
  logic [1:0] last, last_nx;

  // Search begins at the requester after the last completed grant
  always_comb begin
    pick = 2'd0;
    unique case (last)
      2'd0:    pick = bus.req[1] ? 2'd1 :
                      bus.req[2] ? 2'd2 : 2'd0;
      2'd1:    pick = bus.req[2] ? 2'd2 :
                      bus.req[0] ? 2'd0 : 2'd1;
      default: pick = bus.req[0] ? 2'd0 :
                      bus.req[1] ? 2'd1 : 2'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) last <= 2'd2;
    else       last <= last_nx;
  end
`else
  // Same precedence as the B register input mux
  always_comb begin
    pick = 2'd0;
    priority case (1'b1)
      bus.req[0]: pick = 2'd0;
      bus.req[1]: pick = 2'd1;
      bus.req[2]: pick = 2'd2;
      default:    pick = 2'd0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      grant     <= 2'd0;
      b_valid_q <= 1'b0;
      b_src_q   <= 2'd3;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      grant     <= grant_nx;
      b_valid_q <= b_valid_nx;
      b_src_q   <= b_src_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    grant_nx   = grant;
    b_valid_nx = b_valid_q;
    b_src_nx   = b_src_q;
`ifdef B_SEQ_ROUND_ROBIN_EN
    last_nx    = last;
`endif
    if (bus.invalidate) begin
      b_valid_nx = 1'b0;
      b_src_nx   = 2'd3;
    end
    if (bus.flush) begin
      state_nx   = IDLE;
      cnt_nx     = '0;
      b_valid_nx = 1'b0;
      b_src_nx   = 2'd3;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_nx = pick;
            cnt_nx   = CNT_INIT;
            state_nx = LOAD;
          end
        end
        LOAD: begin
          if (cnt == '0) state_nx = ACK;
          else           cnt_nx   = cnt - CNT_W'(1);
        end
        ACK: begin
          state_nx   = IDLE;
          b_valid_nx = 1'b1;
          b_src_nx   = grant;
`ifdef B_SEQ_ROUND_ROBIN_EN
          last_nx    = grant;
`endif
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.load_not_db = (state == LOAD) && (grant == 2'd0);
  assign bus.load_db     = (state == LOAD) && (grant == 2'd1);
  assign bus.load_adr    = (state == LOAD) && (grant == 2'd2);
  assign bus.ack         = (state == ACK) ? (3'b001 << grant) : 3'b000;
  assign bus.busy        = (state != IDLE);
  assign bus.b_valid     = b_valid_q;
  assign bus.b_src       = b_src_q;

endmodule

// File: tb/tb_b_source_sequencer.sv
// Directed bench for b_source_sequencer: two instances (1 and 4 hold cycles)
// with an ack scoreboard per instance.
module tb_b_source_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] qa[$];
  logic [2:0] qb[$];

  b_source_sequencer_if ia ();
  b_source_sequencer_if ib ();

  b_source_sequencer #(.LOAD_CYCLES(1), .CNT_W(4)) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.slave)
  );

  b_source_sequencer #(.LOAD_CYCLES(4), .CNT_W(4)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel=0 -> instance a, sel=1 -> instance b
  task automatic chk_out(string tag, bit sel, logic [2:0] ld,
                         logic [2:0] ak, logic bz, logic bv,
                         logic [1:0] src);
    logic [2:0] o_ld;
    logic [2:0] o_ak;
    logic       o_bz;
    logic       o_bv;
    logic [1:0] o_src;
    if (sel) begin
      o_ld  = {ib.load_adr, ib.load_db, ib.load_not_db};
      o_ak  = ib.ack;
      o_bz  = ib.busy;
      o_bv  = ib.b_valid;
      o_src = ib.b_src;
    end else begin
      o_ld  = {ia.load_adr, ia.load_db, ia.load_not_db};
      o_ak  = ia.ack;
      o_bz  = ia.busy;
      o_bv  = ia.b_valid;
      o_src = ia.b_src;
    end
    chk({tag, ".load"}, 32'(o_ld), 32'(ld));
    chk({tag, ".ack"}, 32'(o_ak), 32'(ak));
    chk({tag, ".busy"}, 32'(o_bz), 32'(bz));
    chk({tag, ".b_valid"}, 32'(o_bv), 32'(bv));
    chk({tag, ".b_src"}, 32'(o_src), 32'(src));
  endtask

  always @(negedge clk) begin
    if (ia.ack != 3'b000) begin
      chk("a_ack_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk("a_ack", 32'(ia.ack), 32'(qa.pop_front()));
    end
    if (ib.ack != 3'b000) begin
      chk("b_ack_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) chk("b_ack", 32'(ib.ack), 32'(qb.pop_front()));
    end
  end

  initial begin
    ia.req = 3'b000; ia.flush = 1'b0; ia.invalidate = 1'b0;
    ib.req = 3'b000; ib.flush = 1'b0; ib.invalidate = 1'b0;

    // reset state
    tick(); tick();
    chk_out("rst_a", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3);
    chk_out("rst_b", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3);
    reset = 1'b0;

    // single db load, 1 hold cycle
    ia.req = 3'b010;
    qa.push_back(3'b010);
    tick();
    chk_out("db_load", 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 2'd3);
    tick();
    chk_out("db_ack", 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 2'd3);
    ia.req = 3'b000;
    tick();
    chk_out("db_done", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2'd1);

    // all requesters held: three loads, period 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ia.req = 3'b111;
`ifdef B_SEQ_ROUND_ROBIN_EN
    qa.push_back(3'b001); qa.push_back(3'b010); qa.push_back(3'b100);
`else
    qa.push_back(3'b001); qa.push_back(3'b001); qa.push_back(3'b001);
`endif
    tick();
    chk_out("arb_first", 1'b0, 3'b001, 3'b000, 1'b1, 1'b0, 2'd3);
    repeat (7) tick();
    ia.req = 3'b000;
    tick();
`ifdef B_SEQ_ROUND_ROBIN_EN
    chk_out("arb_done", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2'd2);
`else
    chk_out("arb_done", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0);
`endif
    tick();
    chk("arb_q_empty", 32'(qa.size()), 32'd0);

    // adl load with 4 hold cycles
    ib.req = 3'b100;
    qb.push_back(3'b100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("adl_hold%0d", i), 1'b1, 3'b100, 3'b000, 1'b1,
              1'b0, 2'd3);
    end
    tick();
    chk_out("adl_ack", 1'b1, 3'b000, 3'b100, 1'b1, 1'b0, 2'd3);
    ib.req = 3'b000;
    tick();
    chk_out("adl_done", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'd2);

    // flush on second LOAD cycle
    ib.req = 3'b001;
    tick();
    chk_out("fl_load1", 1'b1, 3'b001, 3'b000, 1'b1, 1'b1, 2'd2);
    tick();
    ib.flush = 1'b1;
    ib.req = 3'b000;
    tick();
    ib.flush = 1'b0;
    chk_out("fl_abort", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3);
    repeat (6) tick();
    chk_out("fl_quiet", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3);

    // invalidate after a load, then invalidate in ACK cycle
    ia.req = 3'b001;
    qa.push_back(3'b001);
    tick(); tick();
    ia.req = 3'b000;
    tick();
    chk_out("inv_pre", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0);
    ia.invalidate = 1'b1;
    tick();
    ia.invalidate = 1'b0;
    chk_out("inv_clr", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3);
    ia.req = 3'b001;
    qa.push_back(3'b001);
    tick(); tick();
    ia.invalidate = 1'b1;
    ia.req = 3'b000;
    tick();
    ia.invalidate = 1'b0;
    chk_out("inv_ack_wins", 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0);

    // reset mid-LOAD with request still held
    ib.req = 3'b010;
    tick();
    chk_out("rl_load", 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 2'd3);
    reset = 1'b1;
    tick();
    chk_out("rl_reset", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 2'd3);
    reset = 1'b0;
    qb.push_back(3'b010);
    tick();
    chk_out("rl_restart", 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 2'd3);
    repeat (3) tick();
    chk_out("rl_hold", 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 2'd3);
    tick();
    chk_out("rl_ack", 1'b1, 3'b000, 3'b010, 1'b1, 1'b0, 2'd3);
    ib.req = 3'b000;
    tick();
    chk_out("rl_done", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 2'd1);

    tick();
    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/b_source_sequencer.md
Name: b_source_sequencer

Overview:
Sequences the ALU B-side input register. Arbitrates among three requesters that want to load B: the inverted internal data bus, the internal data bus, and the address-low bus. Drives one-hot load strobes for a programmable number of cycles, then acknowledges the winner. Tracks whether B holds valid data and which source loaded it. Sits between the decode/timing logic and the B input register.

Parameters:
LOAD_CYCLES, 1, cycles each load strobe is held asserted (1..15)
CNT_W, 4, width of the load-hold counter; must hold LOAD_CYCLES

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  3  load requests; bit0 not_db, bit1 db, bit2 adl; level, held until ack
flush  input  1  abort any load in progress and invalidate B
invalidate  input  1  clear b_valid without affecting sequencing
load_not_db  output  1  strobe to B register: select inverted db
load_db  output  1  strobe to B register: select db
load_adr  output  1  strobe to B register: select adl
ack  output  3  one-cycle completion pulse, same bit order as req
busy  output  1  high in LOAD or ACK state
b_valid  output  1  B register holds data from a completed load
b_src  output  2  source of current B contents: 0 not_db, 1 db, 2 adl, 3 none

Behaviour:
- Reset (sync, active-high, checked before all else): state=IDLE, counter=0, all load_* =0, ack=0, busy=0, b_valid=0, b_src=3.
- States: IDLE, LOAD, ACK.
- IDLE: if req!=0, latch grant per arbitration, counter=LOAD_CYCLES-1, go LOAD. Strobe asserts the cycle after req is first sampled (latency 1).
- Default arbitration is fixed priority not_db > db > adl, the same precedence as the B register's own mux.
- LOAD: exactly the granted load_* is high. No two load_* are ever high together. Counter decrements each cycle. At counter==0, go ACK. Strobe width is exactly LOAD_CYCLES cycles.
- ACK: all load_* low. ack[grant]=1 for exactly one cycle. b_valid=1 and b_src=grant. Return to IDLE.
- Back-to-back: a new request can be sampled in the IDLE cycle after ACK. Minimum period per load is LOAD_CYCLES+2.
- Request deasserted during LOAD: the load still completes and ack still pulses. The grant is not re-evaluated during LOAD.
- Request rising during LOAD or ACK: it waits and is arbitrated in the next IDLE.
- flush in any state: next cycle state=IDLE, load_* =0, no ack, b_valid=0, b_src=3. flush takes precedence over the ACK transition: a flush sampled in the last LOAD cycle suppresses the ack.
- invalidate: b_valid=0, b_src=3 next cycle. If invalidate coincides with the ACK-cycle update, the ACK update wins and b_valid=1.
- LOAD_CYCLES=0 is illegal. Implementation clamps it to 1.
- busy = (state!=IDLE), registered alongside state.

Optional Feature:
Macro B_SEQ_ROUND_ROBIN_EN.
- Defined: arbitration is round-robin. A 2-bit last-grant pointer (reset to 2) means the search starts at the requester after the last one granted. A flush does not update the pointer.
- Undefined: fixed priority as above, and no pointer register exists.

Test Plan:
- Reset, then req=3'b010, LOAD_CYCLES=1 -> load_db high cycle 1 only; ack=3'b010 in cycle 2; b_valid=1, b_src=1; busy high cycles 1-2.
- req=3'b111 held, fixed priority -> grants in order not_db, not_db, ... (starves others) while bit0 held. With B_SEQ_ROUND_ROBIN_EN -> grants not_db, db, adl, not_db; ack period 3 cycles.
- LOAD_CYCLES=4, req=3'b100 -> load_adr high exactly 4 consecutive cycles, ack[2] on cycle 5, other strobes always 0.
- LOAD_CYCLES=3, req=3'b001, flush on second LOAD cycle -> load_not_db drops next cycle, no ack ever, b_valid=0, b_src=3, state IDLE.
- Completed load (b_valid=1, b_src=0), then invalidate -> b_valid=0, b_src=3. invalidate in the ACK cycle -> b_valid stays 1.
- Assert reset mid-LOAD -> next cycle all outputs at reset values; req still high -> new load begins the cycle after reset deasserts.
